// File: rtl/mem_req_arbiter_pkg.sv
// rtl/mem_req_arbiter_pkg.sv - shared source tags, lock states and constants for mem_req_arbiter
package mem_req_arbiter_pkg;

  localparam logic SRC_INST = 1'b0;
  localparam logic SRC_DATA = 1'b1;

  localparam logic [1:0] SIZE_WORD = 2'd2;

  typedef enum logic [1:0] {
    LOCK_NONE = 2'd0,
    LOCK_INST = 2'd1,
    LOCK_DATA = 2'd2
  } lock_state_e;

endpackage

// File: rtl/mem_req_arbiter_tag_fifo.sv
// rtl/mem_req_arbiter_tag_fifo.sv - in-order 1-bit source tag FIFO for outstanding requests
module tag_fifo #(
  parameter int DEPTH = 4
) (
  input  logic clk,
  input  logic resetn,
  input  logic push,
  input  logic push_tag,
  input  logic pop,
  output logic full,
  output logic empty,
  output logic head
);

  localparam int AW = $clog2(DEPTH);

  // Extra wrap bit distinguishes full from empty when the indices match.
  logic [AW:0]      wr_ptr_q;
  logic [AW:0]      rd_ptr_q;
  logic [DEPTH-1:0] tag_q;

  assign empty = (wr_ptr_q == rd_ptr_q);
  assign full  = (wr_ptr_q[AW] != rd_ptr_q[AW]) &&
                 (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
  assign head  = tag_q[rd_ptr_q[AW-1:0]];

  always_ff @(posedge clk) begin
    if (!resetn) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      tag_q    <= '0;
    end else begin
      if (push && !full) begin
        tag_q[wr_ptr_q[AW-1:0]] <= push_tag;
        wr_ptr_q                <= wr_ptr_q + (AW+1)'(1);
      end
      if (pop && !empty) begin
        rd_ptr_q <= rd_ptr_q + (AW+1)'(1);
      end
    end
  end

endmodule

// File: rtl/mem_req_arbiter.sv
// rtl/mem_req_arbiter.sv - merges inst/data SRAM-like ports onto one downstream port with in-order response routing
module mem_req_arbiter
  import mem_req_arbiter_pkg::*;
#(
  parameter int OUTSTANDING  = 4,
  parameter int STARVE_LIMIT = 8
) (
  input  logic        clk,
  input  logic        resetn,
  input  logic        inst_req,
  input  logic        inst_cache,
  input  logic [31:0] inst_addr,
  output logic        inst_addr_ok,
  output logic        inst_data_ok,
  output logic [31:0] inst_rdata,
  input  logic        data_req,
  input  logic        data_wr,
  input  logic [1:0]  data_size,
  input  logic        data_cache,
  input  logic [31:0] data_addr,
  input  logic [31:0] data_wdata,
  output logic        data_addr_ok,
  output logic        data_data_ok,
  output logic [31:0] data_rdata,
  output logic        mem_req,
  output logic        mem_wr,
  output logic [1:0]  mem_size,
  output logic        mem_cache,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_wdata,
  input  logic        mem_addr_ok,
  input  logic        mem_data_ok,
  input  logic [31:0] mem_rdata,
  output logic        err_o,
  output logic [31:0] perfcnt_inst_stall
);

  localparam int SW = $clog2(STARVE_LIMIT + 1);

  lock_state_e   lock_q, lock_d;
  logic [SW-1:0] starve_q;
  logic          win_valid;
  logic          win_src;
  logic          fifo_full, fifo_empty, fifo_head;
  logic          accept, resp_pop, inst_stall;

  always_ff @(posedge clk) begin
    if (!resetn) lock_q <= LOCK_NONE;
    else         lock_q <= lock_d;
  end

  // A locked source keeps the port only while it still requests; otherwise arbitrate fresh.
  always_comb begin
    win_valid = 1'b0;
    win_src   = SRC_DATA;
    lock_d    = LOCK_NONE;
    if (lock_q == LOCK_INST && inst_req) begin
      win_valid = 1'b1;
      win_src   = SRC_INST;
    end else if (lock_q == LOCK_DATA && data_req) begin
      win_valid = 1'b1;
      win_src   = SRC_DATA;
    end else if (inst_req && data_req) begin
      win_valid = 1'b1;
      win_src   = (starve_q >= SW'(STARVE_LIMIT)) ? SRC_INST : SRC_DATA;
    end else if (inst_req) begin
      win_valid = 1'b1;
      win_src   = SRC_INST;
    end else if (data_req) begin
      win_valid = 1'b1;
      win_src   = SRC_DATA;
    end
    if (mem_req && !mem_addr_ok) begin
      lock_d = (win_src == SRC_INST) ? LOCK_INST : LOCK_DATA;
    end
  end

  assign mem_req      = win_valid && !fifo_full;
  assign accept       = mem_req && mem_addr_ok;
  assign inst_addr_ok = accept && (win_src == SRC_INST);
  assign data_addr_ok = accept && (win_src == SRC_DATA);

  assign mem_wr    = (win_src == SRC_INST) ? 1'b0      : data_wr;
  assign mem_size  = (win_src == SRC_INST) ? SIZE_WORD : data_size;
  assign mem_cache = (win_src == SRC_INST) ? inst_cache : data_cache;
  assign mem_addr  = (win_src == SRC_INST) ? inst_addr : data_addr;
  assign mem_wdata = (win_src == SRC_INST) ? 32'd0     : data_wdata;

  assign resp_pop     = mem_data_ok && !fifo_empty;
  assign inst_data_ok = resp_pop && (fifo_head == SRC_INST);
  assign data_data_ok = resp_pop && (fifo_head == SRC_DATA);
  assign inst_rdata   = mem_rdata;
  assign data_rdata   = mem_rdata;

  assign inst_stall = inst_req && !inst_addr_ok;

  always_ff @(posedge clk) begin
    if (!resetn) begin
      starve_q           <= '0;
      perfcnt_inst_stall <= '0;
      err_o              <= 1'b0;
    end else begin
      if (!inst_stall)                         starve_q <= '0;
      else if (starve_q < SW'(STARVE_LIMIT))   starve_q <= starve_q + SW'(1);
      if (inst_stall) perfcnt_inst_stall <= perfcnt_inst_stall + 32'd1;
      if (mem_data_ok && fifo_empty) err_o <= 1'b1;
    end
  end

  tag_fifo #(
    .DEPTH (OUTSTANDING)
  ) u_tag_fifo (
    .clk      (clk),
    .resetn   (resetn),
    .push     (accept),
    .push_tag (win_src),
    .pop      (resp_pop),
    .full     (fifo_full),
    .empty    (fifo_empty),
    .head     (fifo_head)
  );

endmodule

// File: tb/tb_mem_req_arbiter.sv
// tb/tb_mem_req_arbiter.sv - directed and randomized self-checking bench for mem_req_arbiter
module tb_mem_req_arbiter;

  localparam int OUTSTANDING  = 4;
  localparam int STARVE_LIMIT = 8;

  logic        clk = 1'b0;
  logic        resetn;
  logic        inst_req, inst_cache, inst_addr_ok, inst_data_ok;
  logic [31:0] inst_addr, inst_rdata;
  logic        data_req, data_wr, data_cache, data_addr_ok, data_data_ok;
  logic [1:0]  data_size;
  logic [31:0] data_addr, data_wdata, data_rdata;
  logic        mem_req, mem_wr, mem_cache, mem_addr_ok, mem_data_ok;
  logic [1:0]  mem_size;
  logic [31:0] mem_addr, mem_wdata, mem_rdata;
  logic        err_o;
  logic [31:0] perfcnt_inst_stall;

  always #5 clk = ~clk;

  mem_req_arbiter #(
    .OUTSTANDING  (OUTSTANDING),
    .STARVE_LIMIT (STARVE_LIMIT)
  ) dut (
    .clk (clk), .resetn (resetn),
    .inst_req (inst_req), .inst_cache (inst_cache), .inst_addr (inst_addr),
    .inst_addr_ok (inst_addr_ok), .inst_data_ok (inst_data_ok), .inst_rdata (inst_rdata),
    .data_req (data_req), .data_wr (data_wr), .data_size (data_size),
    .data_cache (data_cache), .data_addr (data_addr), .data_wdata (data_wdata),
    .data_addr_ok (data_addr_ok), .data_data_ok (data_data_ok), .data_rdata (data_rdata),
    .mem_req (mem_req), .mem_wr (mem_wr), .mem_size (mem_size), .mem_cache (mem_cache),
    .mem_addr (mem_addr), .mem_wdata (mem_wdata), .mem_addr_ok (mem_addr_ok),
    .mem_data_ok (mem_data_ok), .mem_rdata (mem_rdata),
    .err_o (err_o), .perfcnt_inst_stall (perfcnt_inst_stall)
  );

  int checks = 0;
  int errors = 0;

  // Reference model: who holds the port, how long inst has waited, tags in flight.
  int          m_lock;
  int          m_starve;
  bit          m_tags[$];
  bit          m_err;
  logic [31:0] m_perf;

  logic [31:0] s_iaddr, s_daddr, s_dwdata, s_rdata;
  logic        s_icache, s_dwr, s_dcache;
  logic [1:0]  s_dsz;

  int          last_grant;
  logic [1:0]  last_resp;
  logic        last_mreq;

  task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic model_reset();
    m_lock = -1;
    m_starve = 0;
    m_tags.delete();
    m_err = 1'b0;
    m_perf = '0;
  endtask

  task automatic stage_random();
    s_iaddr  = $urandom;
    s_daddr  = $urandom;
    s_dwdata = $urandom;
    s_rdata  = $urandom;
    s_icache = 1'($urandom_range(0, 1));
    s_dwr    = 1'($urandom_range(0, 1));
    s_dcache = 1'($urandom_range(0, 1));
    s_dsz    = 2'($urandom_range(0, 2));
  endtask

  task automatic do_reset();
    @(negedge clk);
    resetn = 1'b0;
    inst_req = 1'b0; data_req = 1'b0; mem_addr_ok = 1'b0; mem_data_ok = 1'b0;
    repeat (2) @(posedge clk);
    #1 resetn = 1'b1;
    model_reset();
  endtask

  task automatic step(input bit ir, input bit dr, input bit aok, input bit dok);
    int win;
    bit full, mreq, iaok, daok, pop, idok, ddok;
    @(negedge clk);
    inst_req = ir; inst_cache = s_icache; inst_addr = s_iaddr;
    data_req = dr; data_wr = s_dwr; data_size = s_dsz; data_cache = s_dcache;
    data_addr = s_daddr; data_wdata = s_dwdata;
    mem_addr_ok = aok; mem_data_ok = dok; mem_rdata = s_rdata;
    #1;
    if (m_lock == 0 && ir)           win = 0;
    else if (m_lock == 1 && dr)      win = 1;
    else if (ir && dr)               win = (m_starve >= STARVE_LIMIT) ? 0 : 1;
    else if (ir)                     win = 0;
    else if (dr)                     win = 1;
    else                             win = -1;
    full = (m_tags.size() == OUTSTANDING);
    mreq = (win >= 0) && !full;
    iaok = mreq && aok && (win == 0);
    daok = mreq && aok && (win == 1);
    pop  = dok && (m_tags.size() > 0);
    idok = pop && (m_tags[0] == 1'b0);
    ddok = pop && (m_tags[0] == 1'b1);
    check("ok", {mem_req, inst_addr_ok, data_addr_ok, inst_data_ok, data_data_ok},
          {mreq, iaok, daok, idok, ddok});
    if (mreq)
      check("mem", {mem_addr, mem_wr, mem_size, mem_cache, mem_wdata},
            (win == 0) ? {s_iaddr, 1'b0, 2'd2, s_icache, 32'd0}
                       : {s_daddr, s_dwr, s_dsz, s_dcache, s_dwdata});
    check("rdata", {inst_rdata, data_rdata}, {s_rdata, s_rdata});
    check("err", err_o, m_err);
    check("perf", perfcnt_inst_stall, m_perf);
    last_grant = inst_addr_ok ? 0 : (data_addr_ok ? 1 : -1);
    last_resp  = {inst_data_ok, data_data_ok};
    last_mreq  = mem_req;
    if (pop) void'(m_tags.pop_front());
    if (iaok || daok) m_tags.push_back(win == 1);
    if (dok && !pop) m_err = 1'b1;
    m_lock = (mreq && !aok) ? win : -1;
    if (ir && !iaok) begin
      m_starve = (m_starve < STARVE_LIMIT) ? m_starve + 1 : m_starve;
      m_perf   = m_perf + 32'd1;
    end else begin
      m_starve = 0;
    end
  endtask

  initial begin
    logic [8:0] grants;
    logic [7:0] resp;
    stage_random();
    do_reset();
    step(0, 0, 0, 0);

    // Single fetch: accepted at once, answered two cycles later.
    s_iaddr = 32'h1FC0_0000;
    s_rdata = 32'h2408_0001;
    step(1, 0, 1, 0);
    check("t1_iaok", last_grant, 0);
    step(0, 0, 0, 0);
    step(0, 0, 0, 1);
    check("t1_resp", {last_resp, inst_rdata}, {2'b10, 32'h2408_0001});
    check("t1_err", err_o, 1'b0);

    // Starvation guard: eight data grants, then inst.
    stage_random();
    for (int i = 0; i < 9; i++) begin
      step(1, 1, 1, i > 0);
      grants[i] = (last_grant == 0);
    end
    check("t2_grants", grants, 9'b1_0000_0000);
    step(1, 1, 1, 1);
    check("t2_after", last_grant, 1);
    step(0, 0, 0, 1);

    // Lock holds inst on the port while data rises.
    s_iaddr = 32'h1FC0_0100;
    s_daddr = 32'h8000_1000;
    step(1, 0, 0, 0);
    for (int i = 0; i < 3; i++) begin
      step(1, 1, 0, 0);
      check("t3_addr", mem_addr, 32'h1FC0_0100);
    end
    step(1, 1, 1, 0);
    check("t3_first", last_grant, 0);
    step(0, 1, 1, 0);
    check("t3_second", last_grant, 1);
    step(0, 0, 0, 1);
    step(0, 0, 0, 1);

    // Fill to OUTSTANDING, then drain in order.
    step(1, 0, 1, 0);
    step(0, 1, 1, 0);
    step(1, 0, 1, 0);
    step(0, 1, 1, 0);
    step(1, 1, 1, 0);
    check("t4_full", last_mreq, 1'b0);
    for (int i = 0; i < 4; i++) begin
      step(0, 0, 0, 1);
      resp[7-2*i -: 2] = last_resp;
    end
    check("t4_order", resp, 8'b10_01_10_01);

    // Push and pop together at count 2.
    step(1, 0, 1, 0);
    step(0, 1, 1, 0);
    step(1, 0, 1, 1);
    check("t6_pop", {last_resp, 2'(last_grant)}, {2'b10, 2'd0});
    step(0, 0, 0, 1);
    check("t6_d", last_resp, 2'b01);
    step(0, 0, 0, 1);
    check("t6_i", last_resp, 2'b10);

    // Spurious response on empty FIFO sets sticky error.
    step(0, 0, 0, 1);
    check("t5_none", last_resp, 2'b00);
    step(0, 0, 0, 0);
    check("t5_err", err_o, 1'b1);
    step(0, 0, 0, 0);
    check("t5_sticky", err_o, 1'b1);
    do_reset();
    step(0, 0, 0, 0);
    check("t5_clear", err_o, 1'b0);

    // Reset drops an in-flight tag; its late response is an error.
    step(1, 0, 1, 0);
    do_reset();
    step(0, 0, 0, 1);
    check("t7_none", last_resp, 2'b00);
    step(0, 0, 0, 0);
    check("t7_err", err_o, 1'b1);
    do_reset();

    for (int i = 0; i < 3000; i++) begin
      stage_random();
      if (i == 1500) do_reset();
      step($urandom_range(0, 3) != 0, $urandom_range(0, 2) != 0,
           1'($urandom_range(0, 1)),
           (m_tags.size() > 0) && ($urandom_range(0, 2) == 0));
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/mem_req_arbiter.md
# mem_req_arbiter

Merges the instruction-fetch and data-memory SRAM-like request ports into one downstream SRAM-like port (toward the cache/AXI bridge). Arbitrates address phases with data priority plus an anti-starvation guard, and holds the granted request stable until it is accepted. Records the source of every accepted request in an in-order tag FIFO, and routes each `mem_data_ok`/`mem_rdata` back to the requester that issued it.

## Interface
- `OUTSTANDING`, 4: max accepted-but-unanswered requests; power of 2, ≥2.
- `STARVE_LIMIT`, 8: consecutive denied inst cycles before inst gets priority.
- `clk` in 1: clock.
- `resetn` in 1: reset, synchronous, active-low.
- `inst_req` in 1: fetch request.
- `inst_cache` in 1: cacheable attribute.
- `inst_addr` in 32: physical fetch address.
- `inst_addr_ok` out 1: inst address phase accepted.
- `inst_data_ok` out 1: inst read data valid.
- `inst_rdata` out 32: read data.
- `data_req` in 1: data request.
- `data_wr` in 1: write.
- `data_size` in 2: 0=byte, 1=half, 2=word.
- `data_cache` in 1: cacheable attribute.
- `data_addr` in 32: physical data address.
- `data_wdata` in 32: write data.
- `data_addr_ok` out 1: data address phase accepted.
- `data_data_ok` out 1: data response valid (read data or write ack).
- `data_rdata` out 32: read data.
- `mem_req` out 1: downstream request.
- `mem_wr` out 1: downstream write.
- `mem_size` out 2: downstream size.
- `mem_cache` out 1: downstream cacheable.
- `mem_addr` out 32: downstream address.
- `mem_wdata` out 32: downstream write data.
- `mem_addr_ok` in 1: downstream address accepted.
- `mem_data_ok` in 1: downstream response.
- `mem_rdata` in 32: downstream read data.
- `err_o` out 1: sticky protocol error (response with no outstanding request).
- `perfcnt_inst_stall` out 32: cycles `inst_req`=1 without `inst_addr_ok`.

## Operation
- Sources: inst and data. Inst requests are always reads: `mem_wr`=0, `mem_size`=2, `mem_wdata`=0.
- Arbitration (when unlocked, FIFO not full):
  - Only one source requests: that source wins.
  - Both request: data wins, unless the starve counter ≥ `STARVE_LIMIT`; then inst wins.
- Starve counter: increments (saturating at `STARVE_LIMIT`) each cycle `inst_req`=1 and `inst_addr_ok`=0. Clears on `inst_addr_ok` or `inst_req`=0.
- Lock: when `mem_req`=1 and `mem_addr_ok`=0, the winner is latched. Next cycles, `mem_*` stays driven from the locked source.
  - Lock clears on `mem_addr_ok`.
  - Lock also clears if the locked source drops its req; that same cycle re-arbitrates fresh.
- `mem_req` = (winner's req) and FIFO not full. While full, `mem_req`=0, even if a pop occurs in the same cycle.
- `inst_addr_ok`/`data_addr_ok` = `mem_addr_ok` and `mem_req` and that source is the winner. Never both high.
- On an accepted handshake, push the tag (SRC_INST/SRC_DATA) into the FIFO.
- On `mem_data_ok`, with FIFO non-empty:
  - Pop the head.
  - Assert `inst_data_ok` or `data_data_ok` according to the head tag.
  - `inst_rdata` = `data_rdata` = `mem_rdata` always.
- `mem_data_ok` with FIFO empty: ignored (no pop, no output), and `err_o`←1 until reset.
- Push and pop in the same cycle: allowed when not full; count is unchanged.
- Responses are in order; cancellation is the requester's concern (it still consumes its `data_ok`).

## Timing
- `addr_ok` and `data_ok` paths are combinational, with zero added latency. No response arrives earlier than the cycle after acceptance (downstream guarantee).
- Reset, first cycle after `resetn`=0 sampled:
  - FIFO empty, lock clear, starve counter 0.
  - `err_o`=0, `perfcnt_inst_stall`=0.
  - With requests low, all `*_ok` and `mem_req` outputs are 0.
- Reset mid-transaction drops all tags. Responses arriving afterward set `err_o`.
- FIFO pointers are log2(`OUTSTANDING`) bits plus a wrap bit. Full = pointers equal with wrap bits differing.
- `perfcnt_inst_stall` wraps modulo 2^32.

## Structure
- Add `SRC_INST` (1'b0) and `SRC_DATA` (1'b1) to `common.vh`.
- Sub-module `tag_fifo`: 1-bit wide, depth `OUTSTANDING`, push/pop/full/empty/head outputs, synchronous reset to empty.
- Arbitration, lock and starve logic live in `mem_req_arbiter`.

## Test plan
- Inst only, addr 0x1FC00000, `mem_addr_ok` same cycle, `mem_data_ok` 2 cycles later with 0x24080001 → `inst_addr_ok` cycle 0; `inst_data_ok`=1 and `inst_rdata`=0x24080001 in cycle 2; `err_o`=0.
- Both request every cycle, `mem_addr_ok`=1 continuously, STARVE_LIMIT=8 → data granted 8 cycles, then inst granted on cycle 9 and the counter clears.
- Inst locked with `mem_addr_ok`=0 for 3 cycles while `data_req` rises → `mem_addr` stays `inst_addr`; inst accepted first, data next.
- Issue 4 accepted requests (I,D,I,D) with no response → `mem_req`=0 on a 5th request. Return 4 responses → `inst_data_ok`,`data_data_ok`,`inst_data_ok`,`data_data_ok` in order.
- `mem_data_ok` with FIFO empty → no `*_data_ok`; `err_o`=1 until `resetn`=0.
- Push and pop in the same cycle at count 2 → count stays 2, and the routed tag matches the older entry.
